tm_tape_ctrl: RTL and testbench



---
 rtl/tm_tape_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_tm_tape_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tm_tape_ctrl.sv
// tm_tape_ctrl: step sequencer for the Turing-machine tape RAM.
// It clears the tape to BLANK after reset and owns the head address.
// It runs one step per command: an optional write, a head move, then a read of the new cell.
// The RAM read data comes back on mem_out, one cycle after the address is presented.
// Optional build macro TM_TAPE_WRAP_EN: the head wraps at the tape ends instead of clamping.
module tm_tape_ctrl #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_SPACE = 14,
   parameter int                    HEAD_INIT  = 2**(ADDR_SPACE-1),
   parameter logic [DATA_WIDTH-1:0] BLANK      = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [DATA_WIDTH-1:0] cmd_sym,
   input  logic [1:0]            cmd_move,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_sym,
   output logic                  rsp_edge,
   output logic [ADDR_SPACE-1:0] head_addr,
   output logic                  busy,
   output logic [ADDR_SPACE-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_data,
   output logic                  mem_we,
   input  logic [DATA_WIDTH-1:0] mem_out
);

   typedef enum logic [2:0] {
      S_CLEAR,
      S_IDLE,
      S_EXEC,
      S_FETCH,
      S_WAIT,
      S_RESP
   } state_t;

   localparam logic [ADDR_SPACE-1:0] HEAD_RST = HEAD_INIT[ADDR_SPACE-1:0];
   localparam logic [ADDR_SPACE-1:0] ADDR_MAX = {ADDR_SPACE{1'b1}};

   state_t                  state;
   state_t                  next_state;
   logic [ADDR_SPACE-1:0]   clr_cnt;
   logic                    init_pending;
   logic                    lat_write;
   logic [DATA_WIDTH-1:0]   lat_sym;
   logic [1:0]              lat_move;
   logic [ADDR_SPACE-1:0]   head_next;
   logic                    edge_next;

   // State register; a low rst_n always restarts the tape clear
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_CLEAR;
      end else begin
         state <= next_state;
      end
   end

   // Datapath registers: clear counter, latched command, head, response
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         clr_cnt      <= '0;
         init_pending <= 1'b0;
         lat_write    <= 1'b0;
         lat_sym      <= '0;
         lat_move     <= 2'b00;
         head_addr    <= HEAD_RST;
         rsp_sym      <= '0;
         rsp_edge     <= 1'b0;
      end else begin
         case (state)
            S_CLEAR: begin
               clr_cnt <= clr_cnt + 1'b1;
               if (clr_cnt == ADDR_MAX) begin
                  init_pending <= 1'b1;
               end
            end
            S_IDLE: begin
               if (cmd_valid) begin
                  lat_write <= cmd_write;
                  lat_sym   <= cmd_sym;
                  lat_move  <= cmd_move;
               end
            end
            S_EXEC: begin
               head_addr <= head_next;
               rsp_edge  <= edge_next;
            end
            S_WAIT: begin
               rsp_sym      <= mem_out;
               init_pending <= 1'b0;
            end
            default: begin
            end
         endcase
      end
   end

   // Head move arithmetic with end-of-tape detection
   always_comb begin
      head_next = head_addr;
      edge_next = 1'b0;
      case (lat_move)
         2'b01: begin
            edge_next = (head_addr == '0);
`ifdef TM_TAPE_WRAP_EN
            head_next = head_addr - 1'b1;
`else
            if (head_addr != '0) begin
               head_next = head_addr - 1'b1;
            end
`endif
         end
         2'b10: begin
            edge_next = (head_addr == ADDR_MAX);
`ifdef TM_TAPE_WRAP_EN
            head_next = head_addr + 1'b1;
`else
            if (head_addr != ADDR_MAX) begin
               head_next = head_addr + 1'b1;
            end
`endif
         end
         default: begin
         end
      endcase
   end

   // Next-state sequencing through clear and the step pipeline
   always_comb begin
      next_state = state;
      case (state)
         S_CLEAR: begin
            if (clr_cnt == ADDR_MAX) begin
               next_state = S_FETCH;
            end
         end
         S_IDLE: begin
            if (cmd_valid) begin
               next_state = S_EXEC;
            end
         end
         S_EXEC:  next_state = S_FETCH;
         S_FETCH: next_state = S_WAIT;
         S_WAIT:  next_state = init_pending ? S_IDLE : S_RESP;
         S_RESP: begin
            if (rsp_ready) begin
               next_state = S_IDLE;
            end
         end
         default: next_state = S_CLEAR;
      endcase
   end

   // Output decode: handshakes and the RAM port, write enable gated by reset
   always_comb begin
      cmd_ready = 1'b0;
      rsp_valid = 1'b0;
      busy      = 1'b1;
      mem_we    = 1'b0;
      mem_addr  = head_addr;
      mem_data  = BLANK;
      case (state)
         S_CLEAR: begin
            mem_we   = rst_n;
            mem_addr = clr_cnt;
         end
         S_IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
         end
         S_EXEC: begin
            mem_we   = rst_n & lat_write;
            mem_data = lat_sym;
         end
         S_RESP: begin
            rsp_valid = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_tm_tape_ctrl.sv
// tb_tm_tape_ctrl: directed bench for tm_tape_ctrl with a 16-cell tape and a behavioural RAM.
// Responses are predicted by a tape/head model and queued, then popped when rsp_valid appears.
// Build with TM_TAPE_WRAP_EN defined to exercise the wrapping head.
module tb_tm_tape_ctrl;

   localparam int DW    = 32;
   localparam int AW    = 4;
   localparam int DEPTH = 16;

   logic          clk       = 1'b0;
   logic          rst_n     = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_write = 1'b0;
   logic [DW-1:0] cmd_sym   = '0;
   logic [1:0]    cmd_move  = 2'b00;
   logic          rsp_ready = 1'b1;
   logic          preload   = 1'b1;

   logic          cmd_ready;
   logic          rsp_valid;
   logic [DW-1:0] rsp_sym;
   logic          rsp_edge;
   logic [AW-1:0] head_addr;
   logic          busy;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_data;
   logic          mem_we;
   logic [DW-1:0] mem_out;

   logic [DW-1:0] ram [DEPTH];

   typedef struct {
      logic [DW-1:0] sym;
      logic          edge_flag;
      logic [AW-1:0] head;
   } rsp_t;

   rsp_t          exp_q[$];
   logic [DW-1:0] model_tape [DEPTH];
   int            model_head;
   int            n_tests = 0;
   int            n_fail  = 0;

   tm_tape_ctrl #(
      .DATA_WIDTH (DW),
      .ADDR_SPACE (AW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_sym   (cmd_sym),
      .cmd_move  (cmd_move),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_sym   (rsp_sym),
      .rsp_edge  (rsp_edge),
      .head_addr (head_addr),
      .busy      (busy),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data),
      .mem_we    (mem_we),
      .mem_out   (mem_out)
   );

   always #5 clk = ~clk;

   // Single-port RAM: registered read returning the old word on a write cycle
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < DEPTH; i++) begin
            ram[i] <= 32'hDEAD_0000 + 32'(i);
         end
      end else if (mem_we) begin
         ram[mem_addr] <= mem_data;
      end
      mem_out <= ram[mem_addr];
   end

   // Watchdog so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_tests++;
      assert (observed === expected) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic wait_ready();
      int cnt = 0;
      while (!cmd_ready && cnt < 100) begin
         @(negedge clk);
         cnt++;
      end
      check("ready_timeout", 32'(cmd_ready), 32'd1);
   endtask

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) begin
         model_tape[i] = '0;
      end
      model_head = DEPTH / 2;
   endtask

   task automatic apply_stimulus(input logic wr, input logic [DW-1:0] sym, input logic [1:0] mv);
      rsp_t e;
      int   nh;
      logic ef;
      wait_ready();
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_sym   = sym;
      cmd_move  = mv;
      if (wr) begin
         model_tape[model_head] = sym;
      end
      nh = model_head;
      ef = 1'b0;
      if (mv == 2'b01) begin
         if (model_head == 0) begin
            ef = 1'b1;
`ifdef TM_TAPE_WRAP_EN
            nh = DEPTH - 1;
`endif
         end else begin
            nh = model_head - 1;
         end
      end else if (mv == 2'b10) begin
         if (model_head == DEPTH - 1) begin
            ef = 1'b1;
`ifdef TM_TAPE_WRAP_EN
            nh = 0;
`endif
         end else begin
            nh = model_head + 1;
         end
      end
      model_head  = nh;
      e.sym       = model_tape[nh];
      e.edge_flag = ef;
      e.head      = 4'(nh);
      exp_q.push_back(e);
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_sym   = 32'hFFFF_FFFF;
      cmd_move  = 2'b10;
   endtask

   task automatic check_output(input int hold_cycles);
      int   lat = 1;
      rsp_t e;
      while (!rsp_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check("rsp_latency", 32'(lat), 32'd4);
      check("queue_depth", 32'(exp_q.size()), 32'd1);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
      end else begin
         e.sym       = 'x;
         e.edge_flag = 1'bx;
         e.head      = 'x;
      end
      check("rsp_valid", 32'(rsp_valid), 32'd1);
      check("rsp_sym", rsp_sym, e.sym);
      check("rsp_edge", 32'(rsp_edge), 32'(e.edge_flag));
      check("head_addr", 32'(head_addr), 32'(e.head));
      for (int k = 0; k < hold_cycles; k++) begin
         @(negedge clk);
         check("hold_valid", 32'(rsp_valid), 32'd1);
         check("hold_ready", 32'(cmd_ready), 32'd0);
         check("hold_sym", rsp_sym, e.sym);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      check("rsp_drop", 32'(rsp_valid), 32'd0);
      check("ready_back", 32'(cmd_ready), 32'd1);
   endtask

   initial begin
      int we_cnt;
      int rsp_seen;
      int bad_cells;

      model_reset();

      // Hold reset across a few edges while the RAM is filled with garbage
      repeat (3) @(posedge clk);
      @(negedge clk);
      preload = 1'b0;
      check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      check("rst_busy", 32'(busy), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_sym", rsp_sym, 32'd0);
      check("rst_rsp_edge", 32'(rsp_edge), 32'd0);
      check("rst_head", 32'(head_addr), 32'd8);
      check("rst_mem_we", 32'(mem_we), 32'd0);

      // Release reset and follow the sixteen clear writes
      rst_n = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         #1;
         check("clr_we", 32'(mem_we), 32'd1);
         check("clr_addr", 32'(mem_addr), 32'(i));
         check("clr_data", mem_data, 32'd0);
         @(negedge clk);
      end
      #1;
      check("fetch_we", 32'(mem_we), 32'd0);
      check("fetch_ready", 32'(cmd_ready), 32'd0);
      @(negedge clk);
      check("wait_ready", 32'(cmd_ready), 32'd0);
      @(negedge clk);
      check("idle_ready", 32'(cmd_ready), 32'd1);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_head", 32'(head_addr), 32'd8);
      check("idle_no_rsp", 32'(rsp_valid), 32'd0);
      for (int i = 0; i < DEPTH; i++) begin
         check("clr_cell", ram[i], 32'd0);
      end

      // Write 0x5A and move right, then come back left and read it
      apply_stimulus(1'b1, 32'h5A, 2'b10);
      check_output(0);
      check("ram8_5a", ram[8], 32'h5A);
      apply_stimulus(1'b0, 32'h0, 2'b01);
      check_output(0);

      // Write-then-stay with reserved move code, consumer stalls three cycles
      rsp_ready = 1'b0;
      apply_stimulus(1'b1, 32'h33, 2'b11);
      check_output(3);

      // Nine left moves from head 8 run into the left end
      for (int i = 0; i < 9; i++) begin
         apply_stimulus(1'b0, 32'h0, 2'b01);
         check_output(0);
      end
      check("left9_edge", 32'(rsp_edge), 32'd1);
`ifdef TM_TAPE_WRAP_EN
      check("left9_head", 32'(head_addr), 32'd15);
`else
      check("left9_head", 32'(head_addr), 32'd0);
`endif

      // Abort a write step with reset during its FETCH cycle
      wait_ready();
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_sym   = 32'hAB;
      cmd_move  = 2'b10;
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      check("abort_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n    = 1'b1;
      we_cnt   = 0;
      rsp_seen = 0;
      for (int i = 0; i < 30; i++) begin
         #1;
         if (mem_we) we_cnt++;
         if (rsp_valid) rsp_seen++;
         @(negedge clk);
      end
      check("abort_clear_writes", 32'(we_cnt), 32'd16);
      check("abort_no_rsp", 32'(rsp_seen), 32'd0);
      check("abort_ready", 32'(cmd_ready), 32'd1);
      check("abort_head", 32'(head_addr), 32'd8);
      bad_cells = 0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ram[i] !== 32'd0) bad_cells++;
      end
      check("abort_blank_cells", 32'(bad_cells), 32'd0);
      exp_q.delete();
      model_reset();

      // A normal step after the abort
      apply_stimulus(1'b1, 32'h77, 2'b10);
      check_output(0);
      check("ram8_77", ram[8], 32'h77);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
